// File: rtl/page_pkg.sv
// Shared types and helpers for the page copy sequencer.
// FSM encoding, default page size and page-align mask.
package page_pkg;

  localparam int DEF_PAGE_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] page_align(
    input logic [31:0] addr,
    input int          words
  );
    return addr & ~32'(words - 1);
  endfunction

endpackage

// File: rtl/page_addr_gen.sv
// Latched page base plus running word index.
// One instance drives reads, another drives writes.
module page_addr_gen
  import page_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PAGE_WORDS = DEF_PAGE_WORDS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [ADDR_WIDTH-1:0]       base,
  input  logic                        step,
  output logic [$clog2(PAGE_WORDS):0] idx,
  output logic [ADDR_WIDTH-1:0]       addr
);

  localparam int IW = $clog2(PAGE_WORDS) + 1;

  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
      idx    <= '0;
    end else if (load) begin
      base_q <= base;
      idx    <= '0;
    end else if (step) begin
      idx    <= idx + IW'(1);
    end
  end

  assign addr = base_q + ADDR_WIDTH'(idx);

endmodule

// File: rtl/page_transfer.sv
// Copies one aligned page from source to destination memory,
// holding busy as a CPU stall and pulsing done at the end.
module page_transfer
  import page_pkg::*;
#(
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [6:0]            src_offset,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int IW = $clog2(PAGE_WORDS) + 1;
  localparam logic [IW-1:0] LAST = IW'(PAGE_WORDS - 1);

  state_t state, state_next;
  logic   wp, wp_next;
  logic   load, stall, wr_done;
  logic   last_rd, last_wr;

  logic [IW-1:0]         rd_idx, wr_idx;
  logic [ADDR_WIDTH-1:0] offset_ext, src_page, dst_page;

  assign offset_ext = {{(ADDR_WIDTH-7){src_offset[6]}}, src_offset};
  assign src_page   = ADDR_WIDTH'(page_align(
                        32'(src_base + offset_ext), PAGE_WORDS));
  assign dst_page   = ADDR_WIDTH'(page_align(
                        32'(dst_base), PAGE_WORDS));

  // Strobes drop with reset itself so nothing lands during the reset cycle
  assign wr_en   = wp & ~reset;
  assign stall   = wr_en & ~wr_ready;
  assign wr_done = wr_en & wr_ready;
  assign rd_en   = (state == COPY) & ~stall & ~reset;
  assign load    = (state == IDLE) & start;
  assign last_rd = rd_en & (rd_idx == LAST);
  assign last_wr = wr_done & (wr_idx == LAST);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign wr_data = rd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wp    <= 1'b0;
    end else begin
      state <= state_next;
      wp    <= wp_next;
    end
  end

  always_comb begin
    state_next = state;
    wp_next    = wp;
    if (rd_en)
      wp_next = 1'b1;
    else if (wr_done)
      wp_next = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = COPY;
      COPY:  if (last_rd) state_next = DRAIN;
      DRAIN: if (last_wr) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  page_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAGE_WORDS(PAGE_WORDS)
  ) u_rd (
    .clock(clock),
    .reset(reset),
    .load (load),
    .base (src_page),
    .step (rd_en),
    .idx  (rd_idx),
    .addr (rd_addr)
  );

  page_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAGE_WORDS(PAGE_WORDS)
  ) u_wr (
    .clock(clock),
    .reset(reset),
    .load (load),
    .base (dst_page),
    .step (wr_done),
    .idx  (wr_idx),
    .addr (wr_addr)
  );

endmodule

// File: doc/page_transfer.md
# page_transfer

Sequencer that executes a decoded page instruction by copying one aligned page of words from a source memory to a destination memory. It sits directly downstream of the page instruction decoder. The CPU supplies the register value chosen by the decoder's source select, the decoder's 7-bit signed immediate and the destination base. The block stalls the CPU until the copy completes, then pulses `done`.

## Interface
- `PAGE_WORDS`, 64: words per page; power of two, at least 2.
- `ADDR_WIDTH`, 16: address width of both memories.
- `DATA_WIDTH`, 16: word width.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a copy; sampled only in IDLE.
- `src_base`  in  ADDR_WIDTH  source register value, as selected by the decoder's source select.
- `src_offset`  in  7  decoder immediate, two's complement.
- `dst_base`  in  ADDR_WIDTH  destination address.
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle; CPU stall.
- `done`  out  1  one-cycle pulse when the last write has completed.
- `rd_en`  out  1  source read strobe.
- `rd_addr`  out  ADDR_WIDTH  source read address.
- `rd_data`  in  DATA_WIDTH  source data, valid 1 cycle after `rd_en`, held while `rd_en` is low.
- `wr_en`  out  1  destination write request.
- `wr_ready`  in  1  destination accepts; a write completes on `wr_en & wr_ready`.
- `wr_addr`  out  ADDR_WIDTH  destination write address.
- `wr_data`  out  DATA_WIDTH  driven directly from `rd_data`.

## Operation
- Address arithmetic is modulo 2^ADDR_WIDTH.
  - `src_page = (src_base + sext(src_offset)) & ~(PAGE_WORDS-1)`.
  - `dst_page = dst_base & ~(PAGE_WORDS-1)`.
  - Both are latched on start acceptance; later input changes are ignored.
- FSM states:
  - IDLE: `start` -> COPY; latch the page addresses; clear `rd_idx` and `wr_idx`.
  - COPY: issue reads at `src_page + rd_idx`. The last read (`rd_idx == PAGE_WORDS-1`, with `rd_en`) -> DRAIN.
  - DRAIN: no reads. The final write completes -> DONE.
  - DONE: `done = 1` -> IDLE.
- Stall condition: `stall = wr_en & ~wr_ready`.
  - `rd_en = (state == COPY) & ~stall`.
- Write-pending flag `wp`:
  - Set on any cycle with `rd_en`.
  - Cleared on a completed write with no read in the same cycle.
  - `wr_en = wp`.
- Counters:
  - `wr_addr = dst_page + wr_idx`. `wr_idx` increments on each completed write.
  - `rd_idx` increments on each read.
  - Counter widths are log2(PAGE_WORDS)+1, so they cannot alias on wrap.
- `start` while busy: ignored.
- `start` in the DONE cycle: ignored.
- Reset at any time: state IDLE, all outputs 0, counters and `wp` cleared. No further reads or writes occur; a partially copied page stays partial.
- A page that wraps address 0 cannot occur, because pages are aligned.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` are 0; `rd_addr` and `wr_addr` are 0.
- Start accepted at edge E0:
  - Cycle 1: first read.
  - Cycle 2: first write, together with the second read.
- With `wr_ready` held high:
  - Last read in cycle PAGE_WORDS.
  - Last write in cycle PAGE_WORDS+1 (DRAIN).
  - `done` in cycle PAGE_WORDS+2.
  - Total busy is PAGE_WORDS+2 cycles.
- Each cycle of `wr_ready` low while `wr_en` is high adds exactly one cycle. During that cycle `wr_addr` and `wr_data` hold and no read is issued.
- The source memory holds `rd_data` while `rd_en` is low. This is an ECP5 BRAM output register with clock enable, and it is a required property of the source.
- Reads and writes are one word per cycle at most. Reads never lead completed writes by more than 1.

## Structure
- Shared package `page_pkg`:
  - `PAGE_WORDS` default.
  - FSM state encoding: IDLE=2'd0, COPY=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Page-align mask function.
- Natural sub-module: `page_addr_gen`. It holds the latched base, the index counter and the adder. It is instantiated twice, once for read and once for write.

## Test plan
- Basic copy: PAGE_WORDS=64, `src_base=0x0100`, `src_offset=+3`, `dst_base=0x2000`, `wr_ready=1`.
  - Reads 0x0100–0x013F; the destination holds the source words at 0x2000–0x203F.
  - `done` in cycle 66; busy for 66 cycles.
- Negative offset and alignment: `src_base=0x0005`, `src_offset=-8` (0x78).
  - `src_page = 0xFFC0`; reads 0xFFC0–0xFFFF with no carry into 0x0000.
  - `dst_base=0x2033` aligns to 0x2000.
- Backpressure: `wr_ready` low on cycles 2, 3 and 40.
  - `wr_addr` and `wr_data` stable during the stall; no `rd_en`; all 64 words correct.
  - `done` in cycle 69.
- Start while busy: pulse `start` with different bases in cycle 10 and in the DONE cycle.
  - Both ignored; exactly 64 writes; one `done`.
- Reset mid-copy: assert `reset` in cycle 20.
  - Next cycle all outputs 0 and state IDLE.
  - Exactly 18 writes completed; a new start copies normally.
- Back-to-back: `start` in the cycle after `done`.
  - Second copy accepted; busy resumes one cycle after the IDLE cycle.
